// File: rtl/mul_accumulator.sv
// mul_accumulator: burst multiply-accumulate over a 2x2 array multiplier (top).
// Define MULACC_SAT_EN to saturate acc on overflow instead of wrapping.
module top (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] y
);
  logic p01, p10, p11, c1;
  assign p10 = a[1] & b[0];
  assign p01 = a[0] & b[1];
  assign p11 = a[1] & b[1];
  assign c1  = p10 & p01;
  assign y   = {p11 & c1, p11 ^ c1, p10 ^ p01, a[0] & b[0]};
endmodule

module mul_accumulator #(
  parameter int ACC_W = 6,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [3:0]       prod;
  logic [ACC_W:0]   sum;
  top u_mul (.a(in_a), .b(in_b), .y(prod));
  assign sum       = {1'b0, acc} + {{(ACC_W-3){1'b0}}, prod};
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy      = in_ready | out_valid;
  assign out_acc   = acc;
  assign out_ovf   = ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        cnt   <= len;
        acc   <= '0;
        ovf   <= 1'b0;
        state <= (len == '0) ? DONE : ACCUM;
      end
    end else if (state == ACCUM) begin
      if (in_valid) begin
`ifdef MULACC_SAT_EN
        acc <= (ovf || sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
        acc <= sum[ACC_W-1:0];
`endif
        ovf <= ovf | sum[ACC_W];
        cnt <= cnt - 1'b1;
        if (cnt == LEN_W'(1)) state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: table vectors, corner sequences and random bursts vs. an arithmetic model.
module tb_mul_accumulator;
  localparam int ACC_W = 6;
  localparam int LEN_W = 4;
  localparam int MAXV  = (1 << ACC_W) - 1;
  logic             clk = 1'b0;
  logic             rst_n, start, in_valid, out_ready;
  logic [LEN_W-1:0] len;
  logic [1:0]       in_a, in_b;
  logic             in_ready, busy, out_valid, out_ovf;
  logic [ACC_W-1:0] out_acc;
  int vectors = 0;
  int errs = 0;

  mul_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          l;
    logic [31:0] pa;
    logic [31:0] pb;
    int          gap;
    int          hold;
    int          acc_wrap;
    int          acc_sat;
    int          ovf;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_idle"}, {in_ready, busy, out_valid}, 0);
  endtask

  // Runs one burst to completion; returns captured result and in_ready cycle count.
  task automatic do_burst(input int l, input logic [31:0] pa, input logic [31:0] pb,
                          input int gap, input int hold,
                          output int racc, output int rovf, output int rdy);
    logic [ACC_W-1:0] a0;
    logic             o0;
    check_idle("pre");
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
    rdy   = 0;
    for (int i = 0; i < l; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        if (in_ready) rdy++;
        tick();
      end
      in_valid = 1'b1;
      in_a = pa[2*i +: 2];
      in_b = pb[2*i +: 2];
      if (in_ready) rdy++;
      tick();
    end
    in_valid = 1'b0;
    check("out_valid_latency", int'(out_valid), 1);
    for (int w = 0; w < 20 && !out_valid; w++) tick();
    check("out_valid_wait", int'(out_valid), 1);
    check("in_ready_done", int'(in_ready), 0);
    racc = int'(out_acc);
    rovf = int'(out_ovf);
    a0 = out_acc;
    o0 = out_ovf;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_stable", {out_valid, out_acc, out_ovf}, {1'b1, a0, o0});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("post");
  endtask

  function automatic int exp_acc(input int total);
`ifdef MULACC_SAT_EN
    return total > MAXV ? MAXV : total;
`else
    return total % (MAXV + 1);
`endif
  endfunction

  initial begin
    int racc, rovf, rdy, total;
    logic [31:0] pa, pb;
    tbl[0] = '{4,  32'hF9, 32'hED, 0, 0, 22, 22, 0};
    tbl[1] = '{2,  32'h7,  32'hB,  0, 0, 11, 11, 0};
    tbl[2] = '{8,  {16{2'd3}}, {16{2'd3}}, 0, 1, 8, 63, 1};
    tbl[3] = '{0,  32'h0,  32'h0,  0, 2, 0, 0, 0};
    tbl[4] = '{1,  32'h2,  32'h1,  0, 0, 2, 2, 0};
    tbl[5] = '{15, {16{2'd1}}, {16{2'd3}}, 0, 0, 45, 45, 0};
    tbl[6] = '{7,  {16{2'd3}}, {16{2'd3}}, 1, 0, 63, 63, 0};
    tbl[7] = '{3,  32'h1A, 32'h3A, 2, 5, 11, 11, 0};
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    tick();
    check("reset_outs", {in_ready, busy, out_valid, out_acc, out_ovf}, 0);
    rst_n = 1'b1;
    tick();
    for (int v = 0; v < 8; v++) begin
      do_burst(tbl[v].l, tbl[v].pa, tbl[v].pb, tbl[v].gap, tbl[v].hold, racc, rovf, rdy);
`ifdef MULACC_SAT_EN
      check($sformatf("tbl%0d_acc", v), racc, tbl[v].acc_sat);
`else
      check($sformatf("tbl%0d_acc", v), racc, tbl[v].acc_wrap);
`endif
      check($sformatf("tbl%0d_ovf", v), rovf, tbl[v].ovf);
      check($sformatf("tbl%0d_rdy", v), rdy, tbl[v].l * (tbl[v].gap + 1));
    end
    // Asynchronous reset three beats into a four-beat burst.
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = 2'd3; in_b = 2'd3;
    repeat (3) tick();
    in_valid = 1'b0;
    check("pre_reset_acc", int'(out_acc), 27);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {in_ready, busy, out_valid, out_acc, out_ovf}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_reset", {in_ready, busy, out_valid, out_acc, out_ovf}, 0);
    do_burst(2, 32'h7, 32'hB, 0, 0, racc, rovf, rdy);
    check("reset_next_acc", racc, 11);
    // start pulses during ACCUM and DONE must be ignored.
    start = 1'b1; len = 4'd3;
    tick();
    len = 4'd1;
    for (int i = 0; i < 3; i++) begin
      check("ign_in_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_a = i == 2 ? 2'd2 : 2'd1;
      in_b = i == 0 ? 2'd1 : 2'd2;
      tick();
    end
    in_valid = 1'b0;
    check("ign_done", {out_valid, in_ready, out_acc}, {1'b1, 1'b0, 6'd7});
    repeat (2) tick();
    check("ign_done_hold", {out_valid, out_acc, out_ovf}, {1'b1, 6'd7, 1'b0});
    start = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("ign");
    // Random bursts against the arithmetic model.
    for (int r = 0; r < 25; r++) begin
      int l, gap, hold;
      l = $urandom_range(15, 0);
      gap = $urandom_range(2, 0);
      hold = $urandom_range(3, 0);
      pa = $urandom;
      pb = $urandom;
      total = 0;
      for (int i = 0; i < l; i++) total += int'(pa[2*i +: 2]) * int'(pb[2*i +: 2]);
      do_burst(l, pa, pb, gap, hold, racc, rovf, rdy);
      check($sformatf("rnd%0d_acc", r), racc, exp_acc(total));
      check($sformatf("rnd%0d_ovf", r), rovf, int'(total > MAXV));
      check($sformatf("rnd%0d_rdy", r), rdy, l * (gap + 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
